// File: rtl/div_iter_lz_pkg.sv
// Shared definitions for the leading-zero-skipping iterative divider.
// Holds the FSM state encoding, datapath widths and the divide-by-zero quotient.
// Imported by the divider top and usable by the surrounding execute datapath.
package div_iter_lz_pkg;

    localparam int DIV_W     = 32;
    localparam int CLZ_CNT_W = 6;
    localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_iter_lz.sv
// Iterative restoring divider (DIV/DIVU) that skips leading-zero steps using an external CLZ.
// Latency: done in cycle 32-clz+3 after start; 3 cycles for a zero dividend or zero divisor.
// No backpressure: start is ignored while busy; results are held until the next accepted start.
module div_iter_lz
    import div_iter_lz_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = CLZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    output logic             clz_ena,
    output logic [W-1:0]     clz_op,
    input  logic [CNT_W-1:0] clz_cnt,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [W-1:0]     quot,
    output logic [W-1:0]     rem
);

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

    div_state_t       state_q, state_d;
    logic [W-1:0]     dvd_q, dvd_d;        // |dividend|, shifted out MSB-first during ITER
    logic [W-1:0]     dsr_q, dsr_d;        // |divisor|
    logic [W-1:0]     orig_q, orig_d;      // raw dividend, returned as remainder on divide-by-zero
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             fix_q, fix_d;        // cleared when the sign fix must be skipped
    logic             dz_q, dz_d;

    logic             sa, sb;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       trial, diff;
    logic             ge;

    // Operand magnitudes and one restoring step; the 33-bit compare keeps rem's MSB.
    always_comb begin
        sa    = is_signed & dividend[W-1];
        sb    = is_signed & divisor[W-1];
        abs_a = sa ? (~dividend + 1'b1) : dividend;
        abs_b = sb ? (~divisor + 1'b1) : divisor;
        trial = {rem_q, dvd_q[W-1]};
        diff  = trial - {1'b0, dsr_q};
        ge    = ~diff[W];
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            orig_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            fix_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            orig_q  <= orig_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            fix_q   <= fix_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state and datapath update for each FSM state.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        orig_d  = orig_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        fix_d   = fix_q;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvd_d   = abs_a;
                    dsr_d   = abs_b;
                    orig_d  = dividend;
                    neg_q_d = sa ^ sb;
                    neg_r_d = sa;
                    fix_d   = 1'b1;
                    dz_d    = 1'b0;
                    quot_d  = '0;
                    rem_d   = '0;
                    state_d = S_PREP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (dsr_q == '0) begin
                    dz_d    = 1'b1;
                    quot_d  = DIV0_QUOT;
                    rem_d   = orig_q;
                    fix_d   = 1'b0;
                    state_d = S_FIX;
                end else if (clz_cnt == W_CNT) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    state_d = S_FIX;
                end else begin
                    dvd_d   = dvd_q << clz_cnt;
                    cnt_d   = W_CNT - clz_cnt;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rem_d  = ge ? diff[W-1:0] : trial[W-1:0];
                quot_d = {quot_q[W-2:0], ge};
                dvd_d  = dvd_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (fix_q && neg_q_q) quot_d = ~quot_q + 1'b1;
                if (fix_q && neg_r_q) rem_d  = ~rem_q + 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        clz_ena  = (state_q == S_PREP);
        busy     = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
        done     = (state_q == S_DONE);
        clz_op   = dvd_q;
        div_zero = dz_q;
        quot     = quot_q;
        rem      = rem_q;
    end

endmodule
